// File: rtl/aes_stream_packer_if.sv
// Stream-side bundle for aes_stream_packer: 32-bit word streams on one side,
// 128-bit AES blocks on the other, plus the slot indices of both paths.
interface aes_stream_packer_if #(
  parameter int DW      = 32,
  parameter int N_WORDS = 4
) ();
  localparam int BW = DW * N_WORDS;
  localparam int IW = $clog2(N_WORDS);

  logic          pk_valid_i;
  logic [DW-1:0] pk_data_i;
  logic          pk_ready_o;
  logic          pk_blk_valid_o;
  logic [BW-1:0] pk_blk_data_o;
  logic          pk_blk_ready_i;
  logic          up_blk_valid_i;
  logic [BW-1:0] up_blk_data_i;
  logic          up_blk_ready_o;
  logic          up_valid_o;
  logic [DW-1:0] up_data_o;
  logic          up_ready_i;
  logic [IW-1:0] pk_idx_o;
  logic [IW-1:0] up_idx_o;

  modport slave (
    input  pk_valid_i, pk_data_i, pk_blk_ready_i,
    input  up_blk_valid_i, up_blk_data_i, up_ready_i,
    output pk_ready_o, pk_blk_valid_o, pk_blk_data_o,
    output up_blk_ready_o, up_valid_o, up_data_o,
    output pk_idx_o, up_idx_o
  );

  modport master (
    output pk_valid_i, pk_data_i, pk_blk_ready_i,
    output up_blk_valid_i, up_blk_data_i, up_ready_i,
    input  pk_ready_o, pk_blk_valid_o, pk_blk_data_o,
    input  up_blk_ready_o, up_valid_o, up_data_o,
    input  pk_idx_o, up_idx_o
  );
endinterface

// File: rtl/aes_stream_packer.sv
// Width adapter between 32-bit streamer beats and 128-bit AES blocks:
// a pack path (words -> block) and an independent unpack path (block -> words).
module aes_stream_packer #(
  parameter int DW      = 32,
  parameter int N_WORDS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  aes_stream_packer_if.slave  bus
);
  localparam int             BW   = DW * N_WORDS;
  localparam int             IW   = $clog2(N_WORDS);
  localparam logic [IW-1:0]  LAST = IW'(N_WORDS - 1);

  logic [IW-1:0]              pk_idx;
  logic [(N_WORDS-1)*DW-1:0]  pk_stage;
  logic [BW-1:0]              pk_blk;
  logic                       pk_blk_valid;
  logic                       pk_last;
  logic                       pk_ready;
  logic                       pk_acc;

  // Only the closing word needs the block register, so earlier words keep
  // flowing into the staging register while a finished block waits.
  assign pk_last  = (pk_idx == LAST);
  assign pk_ready = ~pk_last | ~pk_blk_valid | bus.pk_blk_ready_i;
  assign pk_acc   = bus.pk_valid_i & pk_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pk_idx       <= '0;
      pk_stage     <= '0;
      pk_blk       <= '0;
      pk_blk_valid <= 1'b0;
    end else if (clear_i) begin
      pk_idx       <= '0;
      pk_stage     <= '0;
      pk_blk       <= '0;
      pk_blk_valid <= 1'b0;
    end else begin
      if (pk_acc) begin
        if (pk_last) begin
          pk_blk <= {bus.pk_data_i, pk_stage};
          pk_idx <= '0;
        end else begin
          pk_stage[pk_idx*DW +: DW] <= bus.pk_data_i;
          pk_idx                    <= pk_idx + 1'b1;
        end
      end
      if (pk_acc && pk_last)
        pk_blk_valid <= 1'b1;
      else if (bus.pk_blk_ready_i)
        pk_blk_valid <= 1'b0;
    end
  end

  assign bus.pk_ready_o     = pk_ready;
  assign bus.pk_blk_valid_o = pk_blk_valid;
  assign bus.pk_blk_data_o  = pk_blk;
  assign bus.pk_idx_o       = pk_idx;

  typedef enum logic {IDLE, EMIT} up_state_t;

  up_state_t      up_state;
  logic [IW-1:0]  up_idx;
  logic [BW-1:0]  up_blk;
  logic           up_valid;
  logic           up_last;
  logic           up_blk_ready;

  // The last word's handshake frees the block register in the same cycle,
  // letting the next block load without a bubble.
  assign up_last      = (up_idx == LAST);
  assign up_blk_ready = (up_state == IDLE) | (up_last & bus.up_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      up_state <= IDLE;
      up_idx   <= '0;
      up_blk   <= '0;
      up_valid <= 1'b0;
    end else if (clear_i) begin
      up_state <= IDLE;
      up_idx   <= '0;
      up_blk   <= '0;
      up_valid <= 1'b0;
    end else begin
      case (up_state)
        IDLE: begin
          if (bus.up_blk_valid_i) begin
            up_blk   <= bus.up_blk_data_i;
            up_idx   <= '0;
            up_state <= EMIT;
            up_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (bus.up_ready_i) begin
            if (up_last) begin
              up_idx <= '0;
              if (bus.up_blk_valid_i) begin
                up_blk <= bus.up_blk_data_i;
              end else begin
                up_state <= IDLE;
                up_valid <= 1'b0;
              end
            end else begin
              up_idx <= up_idx + 1'b1;
            end
          end
        end
        default: begin
          up_state <= IDLE;
          up_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.up_blk_ready_o = up_blk_ready;
  assign bus.up_valid_o     = up_valid;
  assign bus.up_data_o      = up_blk[up_idx*DW +: DW];
  assign bus.up_idx_o       = up_idx;
endmodule

// File: tb/tb_aes_stream_packer.sv
// Bench for aes_stream_packer: pack-path vector table, hand-written unpack,
// clear and async-reset sequences, then random traffic against a queue model.
module tb_aes_stream_packer;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int BW = DW * N;

  localparam logic [DW-1:0] W0 = 32'h03020100, W1 = 32'h07060504;
  localparam logic [DW-1:0] W2 = 32'h0B0A0908, W3 = 32'h0F0E0D0C;
  localparam logic [DW-1:0] W4 = 32'h13121110, W5 = 32'h17161514;
  localparam logic [DW-1:0] W6 = 32'h1B1A1918, W7 = 32'h1F1E1D1C;
  localparam logic [BW-1:0] B1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [BW-1:0] B2 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [BW-1:0] UB1 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [BW-1:0] UB2 = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [BW-1:0] UB3 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear_i = 1'b0;
  always #5 clk = ~clk;

  aes_stream_packer_if #(.DW(DW), .N_WORDS(N)) bus ();

  aes_stream_packer #(.DW(DW), .N_WORDS(N)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_b(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.pk_valid_i     = 1'b0;
    bus.pk_data_i      = '0;
    bus.pk_blk_ready_i = 1'b0;
    bus.up_blk_valid_i = 1'b0;
    bus.up_blk_data_i  = '0;
    bus.up_ready_i     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          pv;
    logic [DW-1:0] pd;
    logic          br;
    logic          e_rdy;
    logic          e_bv;
    logic [BW-1:0] e_bd;
    int            e_idx;
  } pk_vec_t;

  pk_vec_t tbl[19];

  // Reference model state for the random phase.
  logic [DW-1:0] m_words[$];
  logic [BW-1:0] m_blocks[$];
  logic [DW-1:0] m_up[$];

  initial begin
    logic [BW-1:0] blk;
    logic [BW-1:0] ub;
    int k;
    logic e_rdy, e_bv, e_uv, e_ubr, ur, br, pv, ubv;

    tbl[0]  = '{1'b1, W0, 1'b1, 1'b1, 1'b0, '0, 0};
    tbl[1]  = '{1'b1, W1, 1'b1, 1'b1, 1'b0, '0, 1};
    tbl[2]  = '{1'b1, W2, 1'b1, 1'b1, 1'b0, '0, 2};
    tbl[3]  = '{1'b1, W3, 1'b1, 1'b1, 1'b0, '0, 3};
    tbl[4]  = '{1'b0, '0, 1'b1, 1'b1, 1'b1, B1, 0};
    tbl[5]  = '{1'b0, '0, 1'b1, 1'b1, 1'b0, B1, 0};
    tbl[6]  = '{1'b1, W0, 1'b0, 1'b1, 1'b0, B1, 0};
    tbl[7]  = '{1'b1, W1, 1'b0, 1'b1, 1'b0, B1, 1};
    tbl[8]  = '{1'b1, W2, 1'b0, 1'b1, 1'b0, B1, 2};
    tbl[9]  = '{1'b1, W3, 1'b0, 1'b1, 1'b0, B1, 3};
    tbl[10] = '{1'b1, W4, 1'b0, 1'b1, 1'b1, B1, 0};
    tbl[11] = '{1'b1, W5, 1'b0, 1'b1, 1'b1, B1, 1};
    tbl[12] = '{1'b1, W6, 1'b0, 1'b1, 1'b1, B1, 2};
    tbl[13] = '{1'b1, W7, 1'b0, 1'b0, 1'b1, B1, 3};
    tbl[14] = '{1'b1, W7, 1'b0, 1'b0, 1'b1, B1, 3};
    tbl[15] = '{1'b1, W7, 1'b1, 1'b1, 1'b1, B1, 3};
    tbl[16] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, B2, 0};
    tbl[17] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, B2, 0};
    tbl[18] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, B2, 0};

    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    chk_1("rst_pk_ready", bus.pk_ready_o, 1'b1);
    chk_1("rst_pk_blk_valid", bus.pk_blk_valid_o, 1'b0);
    chk_b("rst_pk_blk_data", bus.pk_blk_data_o, '0);
    chk_i("rst_pk_idx", int'(bus.pk_idx_o), 0);
    chk_1("rst_up_blk_ready", bus.up_blk_ready_o, 1'b1);
    chk_1("rst_up_valid", bus.up_valid_o, 1'b0);
    chk_i("rst_up_idx", int'(bus.up_idx_o), 0);
    rst_ni = 1'b1;
    tick();

    // Pack path vector table
    for (int i = 0; i < 19; i++) begin
      bus.pk_valid_i     = tbl[i].pv;
      bus.pk_data_i      = tbl[i].pd;
      bus.pk_blk_ready_i = tbl[i].br;
      #1;
      chk_1($sformatf("tbl%0d_pk_ready", i), bus.pk_ready_o, tbl[i].e_rdy);
      chk_1($sformatf("tbl%0d_blk_valid", i), bus.pk_blk_valid_o, tbl[i].e_bv);
      chk_b($sformatf("tbl%0d_blk_data", i), bus.pk_blk_data_o, tbl[i].e_bd);
      chk_i($sformatf("tbl%0d_pk_idx", i), int'(bus.pk_idx_o), tbl[i].e_idx);
      tick();
    end
    idle_inputs();

    // Unpack streaming: two back-to-back blocks
    bus.up_blk_valid_i = 1'b1;
    bus.up_blk_data_i  = UB1;
    bus.up_ready_i     = 1'b1;
    #1;
    chk_1("ustr_idle_ready", bus.up_blk_ready_o, 1'b1);
    chk_1("ustr_idle_valid", bus.up_valid_o, 1'b0);
    tick();
    for (int b = 0; b < 8; b++) begin
      bus.up_blk_valid_i = (b < 4);
      bus.up_blk_data_i  = (b < 4) ? UB2 : '0;
      bus.up_ready_i     = 1'b1;
      #1;
      blk = (b < 4) ? UB1 : UB2;
      chk_1($sformatf("ustr%0d_valid", b), bus.up_valid_o, 1'b1);
      chk_w($sformatf("ustr%0d_data", b), bus.up_data_o, blk[(b % 4)*DW +: DW]);
      chk_i($sformatf("ustr%0d_idx", b), int'(bus.up_idx_o), b % 4);
      chk_1($sformatf("ustr%0d_blk_ready", b), bus.up_blk_ready_o, (b % 4) == 3);
      tick();
    end
    idle_inputs();
    #1;
    chk_1("ustr_end_valid", bus.up_valid_o, 1'b0);
    chk_1("ustr_end_blk_ready", bus.up_blk_ready_o, 1'b1);
    tick();

    // Unpack stall: ready alternates, each word held until taken
    bus.up_blk_valid_i = 1'b1;
    bus.up_blk_data_i  = UB3;
    tick();
    bus.up_blk_valid_i = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      bus.up_ready_i = (c % 2 == 1);
      #1;
      chk_1($sformatf("ustall%0d_valid", c), bus.up_valid_o, 1'b1);
      chk_w($sformatf("ustall%0d_data", c), bus.up_data_o, UB3[k*DW +: DW]);
      chk_i($sformatf("ustall%0d_idx", c), int'(bus.up_idx_o), k);
      if (bus.up_ready_i) k++;
      tick();
    end
    idle_inputs();
    #1;
    chk_1("ustall_end_valid", bus.up_valid_o, 1'b0);
    tick();

    // Clear mid-operation; clear also beats handshakes in its own cycle
    bus.pk_valid_i = 1'b1; bus.pk_data_i = 32'hAAAA0000; bus.pk_blk_ready_i = 1'b1;
    bus.up_blk_valid_i = 1'b1; bus.up_blk_data_i = UB1; bus.up_ready_i = 1'b0;
    tick();
    bus.pk_data_i = 32'hAAAA0001; bus.up_blk_valid_i = 1'b0; bus.up_ready_i = 1'b1;
    tick();
    clear_i = 1'b1;
    bus.pk_data_i = 32'hAAAA0002; bus.up_blk_valid_i = 1'b1; bus.up_blk_data_i = UB2;
    tick();
    clear_i = 1'b0;
    idle_inputs();
    #1;
    chk_1("clr_pk_blk_valid", bus.pk_blk_valid_o, 1'b0);
    chk_1("clr_up_valid", bus.up_valid_o, 1'b0);
    chk_i("clr_pk_idx", int'(bus.pk_idx_o), 0);
    chk_i("clr_up_idx", int'(bus.up_idx_o), 0);
    chk_1("clr_pk_ready", bus.pk_ready_o, 1'b1);
    chk_1("clr_up_blk_ready", bus.up_blk_ready_o, 1'b1);
    chk_b("clr_pk_blk_data", bus.pk_blk_data_o, '0);
    chk_w("clr_up_data", bus.up_data_o, '0);
    tick();
    bus.pk_blk_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.pk_valid_i = 1'b1;
      bus.pk_data_i  = 32'hC0C0C000 + i;
      tick();
    end
    bus.pk_valid_i = 1'b0;
    #1;
    chk_1("clr_after_blk_valid", bus.pk_blk_valid_o, 1'b1);
    chk_b("clr_after_blk_data", bus.pk_blk_data_o, 128'hC0C0C003_C0C0C002_C0C0C001_C0C0C000);
    tick();
    idle_inputs();
    tick();

    // Asynchronous reset in the middle of EMIT and a partial pack block
    bus.up_blk_valid_i = 1'b1; bus.up_blk_data_i = UB1;
    bus.pk_valid_i = 1'b1; bus.pk_data_i = W0;
    tick();
    bus.up_blk_valid_i = 1'b0; bus.pk_data_i = W1;
    tick();
    idle_inputs();
    #1;
    chk_1("arst_pre_up_valid", bus.up_valid_o, 1'b1);
    chk_i("arst_pre_pk_idx", int'(bus.pk_idx_o), 2);
    #1;
    rst_ni = 1'b0;
    #1;
    chk_1("arst_up_valid", bus.up_valid_o, 1'b0);
    chk_1("arst_up_blk_ready", bus.up_blk_ready_o, 1'b1);
    chk_i("arst_up_idx", int'(bus.up_idx_o), 0);
    chk_i("arst_pk_idx", int'(bus.pk_idx_o), 0);
    chk_w("arst_up_data", bus.up_data_o, '0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    #1;
    chk_1("arst_rel_up_blk_ready", bus.up_blk_ready_o, 1'b1);
    chk_1("arst_rel_up_valid", bus.up_valid_o, 1'b0);
    tick();

    // Random traffic against the queue model
    m_words.delete(); m_blocks.delete(); m_up.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear_i = ($urandom_range(0, 149) == 0);
      pv  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 2) != 0);
      ubv = ($urandom_range(0, 2) != 0);
      ur  = ($urandom_range(0, 3) != 0);
      ub  = {$urandom, $urandom, $urandom, $urandom};
      bus.pk_valid_i = pv; bus.pk_data_i = $urandom; bus.pk_blk_ready_i = br;
      bus.up_blk_valid_i = ubv; bus.up_blk_data_i = ub; bus.up_ready_i = ur;
      #1;
      e_bv  = (m_blocks.size() != 0);
      e_rdy = (m_words.size() != N-1) || !e_bv || br;
      e_uv  = (m_up.size() != 0);
      e_ubr = (m_up.size() == 0) || (m_up.size() == 1 && ur);
      chk_1("rnd_pk_ready", bus.pk_ready_o, e_rdy);
      chk_1("rnd_pk_blk_valid", bus.pk_blk_valid_o, e_bv);
      chk_i("rnd_pk_idx", int'(bus.pk_idx_o), m_words.size());
      if (e_bv) chk_b("rnd_pk_blk_data", bus.pk_blk_data_o, m_blocks[0]);
      chk_1("rnd_up_valid", bus.up_valid_o, e_uv);
      chk_1("rnd_up_blk_ready", bus.up_blk_ready_o, e_ubr);
      chk_i("rnd_up_idx", int'(bus.up_idx_o), e_uv ? N - m_up.size() : 0);
      if (e_uv) chk_w("rnd_up_data", bus.up_data_o, m_up[0]);
      if (clear_i) begin
        m_words.delete(); m_blocks.delete(); m_up.delete();
      end else begin
        if (e_bv && br) void'(m_blocks.pop_front());
        if (pv && e_rdy) begin
          m_words.push_back(bus.pk_data_i);
          if (m_words.size() == N) begin
            for (int j = 0; j < N; j++) blk[j*DW +: DW] = m_words[j];
            m_blocks.push_back(blk);
            m_words.delete();
          end
        end
        if (e_uv && ur) void'(m_up.pop_front());
        if (ubv && e_ubr)
          for (int j = 0; j < N; j++) m_up.push_back(ub[j*DW +: DW]);
      end
      tick();
    end
    clear_i = 1'b0;
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
